// File: rtl/cpu_pkg.sv
// Shared CPU definitions: datapath widths, reset PC and fetch FSM encoding.
// Fetch state constants stay plain localparams so legacy code can keep comparing raw 2-bit values.
package cpu_pkg;

    localparam int unsigned INSTR_W = 32;
    localparam int unsigned ADDR_W  = 32;
    localparam int unsigned JFIELD_W = 28;

    localparam logic [ADDR_W-1:0] RESET_PC_DEFAULT = 32'h0000_0000;

    localparam logic [1:0] FETCH_IDLE = 2'd0;
    localparam logic [1:0] FETCH_REQ  = 2'd1;
    localparam logic [1:0] FETCH_HOLD = 2'd2;

    // Branch targets are forced onto a word boundary.
    function automatic logic [ADDR_W-1:0] word_align(input logic [ADDR_W-1:0] addr);
        return addr & ~ADDR_W'(3);
    endfunction

endpackage

// File: rtl/pc_next_sel.sv
// Next-PC selection: jump (region from pc_plus4) beats branch, which beats sequential.
// Purely combinational; the caller decides when the result is used.
module pc_next_sel
    import cpu_pkg::*;
(
    input  logic [ADDR_W-1:0]   pc_plus4,
    input  logic                jump,
    input  logic [JFIELD_W-1:0] jump_field,
    input  logic                branch,
    input  logic [ADDR_W-1:0]   branch_offset,
    output logic [ADDR_W-1:0]   next_pc
);

    always_comb begin
        next_pc = pc_plus4;
        if (jump) begin
            next_pc = {pc_plus4[ADDR_W-1:JFIELD_W], jump_field};
        end else if (branch) begin
            next_pc = word_align(pc_plus4 + branch_offset);
        end
    end

endmodule

// File: rtl/fetch_pc_unit.sv
// Instruction-fetch stage: owns the PC, fetches over a req/ready handshake and holds
// one instruction for decode until it is consumed.
module fetch_pc_unit
    import cpu_pkg::*;
#(
    parameter logic [ADDR_W-1:0] RESET_PC = RESET_PC_DEFAULT
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                stall,
    input  logic                jump,
    input  logic [JFIELD_W-1:0] jump_field,
    input  logic                branch,
    input  logic [ADDR_W-1:0]   branch_offset,
    output logic                imem_req,
    output logic [ADDR_W-1:0]   imem_addr,
    input  logic                imem_ready,
    input  logic [INSTR_W-1:0]  imem_rdata,
    output logic [INSTR_W-1:0]  instr,
    output logic                instr_valid,
    output logic [ADDR_W-1:0]   pc,
    output logic [ADDR_W-1:0]   pc_plus4
);

    logic [1:0]        state;
    logic [ADDR_W-1:0] fetch_pc;
    logic [ADDR_W-1:0] next_pc;
    logic              consume;

    // Handshake outputs are pure state decodes, so imem_ready never reaches imem_req.
    assign imem_req    = (state == FETCH_REQ);
    assign instr_valid = (state == FETCH_HOLD);
    assign imem_addr   = fetch_pc;
    assign pc_plus4    = pc + ADDR_W'(4);
    assign consume     = instr_valid && !stall;

    pc_next_sel u_pc_next_sel (
        .pc_plus4      (pc_plus4),
        .jump          (jump),
        .jump_field    (jump_field),
        .branch        (branch),
        .branch_offset (branch_offset),
        .next_pc       (next_pc)
    );

    always_ff @(posedge clock) begin
        if (reset) begin
            state    <= FETCH_IDLE;
            fetch_pc <= RESET_PC;
            instr    <= '0;
            pc       <= RESET_PC;
        end else begin
            case (state)
                FETCH_IDLE: begin
                    state <= FETCH_REQ;
                end
                FETCH_REQ: begin
                    if (imem_ready) begin
                        instr <= imem_rdata;
                        pc    <= fetch_pc;
                        state <= FETCH_HOLD;
                    end
                end
                FETCH_HOLD: begin
                    if (consume) begin
                        fetch_pc <= next_pc;
                        state    <= FETCH_REQ;
                    end
                end
                default: begin
                    state <= FETCH_IDLE;
                end
            endcase
        end
    end

endmodule
